// File: rtl/fpu_result_reader_pkg.sv
// Shared definitions for the FPU result read-out path: frame header layout,
// exception flag bit positions and the framing FSM state encoding.
package fpu_result_reader_pkg;

  localparam logic [3:0] HDR_SYNC = 4'hA;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_MSB  = 2'd2,
    ST_LSB  = 2'd3
  } state_e;

  // Header byte: sync nibble followed by the flags in {NV, OF, UF, NX} order
  function automatic logic [7:0] hdrByte(input logic [3:0] flags);
    return {HDR_SYNC, flags[FLAG_NV], flags[FLAG_OF], flags[FLAG_UF], flags[FLAG_NX]};
  endfunction

endpackage

// File: rtl/fpu_result_reader_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data; pushes when full and pops
// when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // DEPTH is a power of two, so plain pointer increment wraps correctly
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpu_result_reader.sv
// Buffers FPU results with their exception flags and streams each one as a
// 3-byte frame (header, MSB, LSB) over a registered valid/ready byte link.
module fpu_result_reader
  import fpu_result_reader_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int FLAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid_i,
  input  logic [DATA_W-1:0]          res_data_i,
  input  logic [FLAG_W-1:0]          res_flags_i,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_last_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
  output logic                       ovf_o,
  input  logic                       ovf_clr_i
);

  localparam int ENTRY_W = DATA_W + FLAG_W;

  state_e             state_q;
  logic [ENTRY_W-1:0] frame_q;
  logic               txValid_q;
  logic [7:0]         txData_q;
  logic               txLast_q;
  logic               ovf_q;

  logic [ENTRY_W-1:0] fifoHead;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               fifoPush;
  logic               fifoPop;
  logic               resDrop;

  // Fullness is judged on the pre-edge count, so a push into a full FIFO is
  // dropped even if the FSM pops in the same cycle.
  assign fifoPush = res_valid_i && !fifoFull;
  assign resDrop  = res_valid_i && fifoFull;

  always_comb begin
    fifoPop = 1'b0;
    if (!fifoEmpty && (state_q == ST_IDLE || (state_q == ST_LSB && tx_ready_i)))
      fifoPop = 1'b1;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .wdata_i ({res_flags_i, res_data_i}),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifo_count_o)
  );

  // Framing FSM; every output byte is loaded one state ahead so the link
  // sees only flops, and a stalled byte simply stays put.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      txValid_q <= 1'b0;
      txData_q  <= '0;
      txLast_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifoPop) begin
            frame_q   <= fifoHead;
            state_q   <= ST_HDR;
            txValid_q <= 1'b1;
            txData_q  <= hdrByte(fifoHead[ENTRY_W-1 -: FLAG_W]);
            txLast_q  <= 1'b0;
          end
        end
        ST_HDR: begin
          if (tx_ready_i) begin
            state_q  <= ST_MSB;
            txData_q <= frame_q[DATA_W-1 -: 8];
          end
        end
        ST_MSB: begin
          if (tx_ready_i) begin
            state_q  <= ST_LSB;
            txData_q <= frame_q[7:0];
            txLast_q <= 1'b1;
          end
        end
        ST_LSB: begin
          if (tx_ready_i) begin
            if (fifoPop) begin
              frame_q   <= fifoHead;
              state_q   <= ST_HDR;
              txValid_q <= 1'b1;
              txData_q  <= hdrByte(fifoHead[ENTRY_W-1 -: FLAG_W]);
              txLast_q  <= 1'b0;
            end else begin
              state_q   <= ST_IDLE;
              txValid_q <= 1'b0;
              txData_q  <= '0;
              txLast_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set
  always_ff @(posedge clk) begin
    if (!rst)          ovf_q <= 1'b0;
    else if (resDrop)  ovf_q <= 1'b1;
    else if (ovf_clr_i) ovf_q <= 1'b0;
  end

  assign tx_valid_o = txValid_q;
  assign tx_data_o  = txData_q;
  assign tx_last_o  = txLast_q;
  assign ovf_o      = ovf_q;

endmodule

// File: doc/fpu_result_reader.md
Name: fpu_result_reader

Overview:
Reads 16-bit FPU results and their exception flags out of the datapath and streams them as bytes to a host-side link. Results are buffered in a small FIFO and serialised as 3-byte frames (header, MSB, LSB) over a valid/ready byte stream. It sits downstream of the FPU output registers and is the read-out counterpart to the operand/result register bank.

Parameters:
DATA_W, 16, result width; fixed at 16, frame format depends on it
DEPTH, 4, FIFO entries; power of two, at least 2
FLAG_W, 4, exception flag width: {NV, OF, UF, NX}

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
res_valid  in  1  result present this cycle (single-cycle strobe per result)
res_data  in  16  FPU result (half-precision bits)
res_flags  in  4  exception flags for res_data
tx_valid  out  1  tx_data holds a valid byte
tx_ready  in  1  sink accepts byte when tx_valid && tx_ready
tx_data  out  8  frame byte
tx_last  out  1  high on final byte (LSB) of a frame
fifo_count  out  clog2(DEPTH+1)  entries currently buffered
ovf  out  1  sticky: a result was dropped because the FIFO was full
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (rst low at a clock edge): FIFO emptied, pointers 0, fifo_count=0, ovf=0, tx_valid=0, tx_data=0, tx_last=0, FSM=IDLE. An in-flight frame is discarded, not resumed.
- Push: at an edge with res_valid=1 and fifo_count<DEPTH, write {res_flags,res_data} at the write pointer. Pointers wrap modulo DEPTH.
- Full: with res_valid=1 and fifo_count==DEPTH, drop the result and set ovf. Fullness uses the pre-edge count, so a push with a same-cycle pop while full is still dropped.
- ovf: set on a drop, cleared by ovf_clr. If a drop and ovf_clr occur in the same cycle, set wins.
- fifo_count: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head into the frame register and go to HDR.
  - HDR: tx_data = {4'hA, flags}.
  - MSB: tx_data = data[15:8].
  - LSB: tx_data = data[7:0], tx_last = 1.
- Transitions:
  - HDR to MSB and MSB to LSB each happen on a handshake.
  - On the LSB handshake: if the FIFO is not empty, pop the next entry and go to HDR in the same edge (no bubble); otherwise go to IDLE.
- tx_valid = 1 in HDR, MSB and LSB; 0 in IDLE.
- Stall rule: while tx_valid && !tx_ready, tx_data and tx_last hold stable.
- Latency: res_valid sampled at edge N into an empty, idle block gives tx_valid=1 with the header byte after edge N+1.
- Throughput: one frame per 3 cycles with tx_ready held high.
- Outputs are registered: tx_data, tx_last and tx_valid come from flops, not combinationally from tx_ready.

Decomposition:
- Shared package holds:
  - the frame header sync nibble constant 4'hA;
  - flag bit indices NV=3, OF=2, UF=1, NX=0;
  - the FSM state encoding IDLE=0, HDR=1, MSB=2, LSB=3.
- Sub-module sync_fifo (DATA_W+FLAG_W wide, DEPTH deep, with push, pop, full, empty and count) is instantiated once.
- Framing FSM and the ovf flag live in the top module.

Test Plan:
1. Single result: push res_data=16'h3C00, flags=4'b0001, tx_ready=1 -> after edge N+1, bytes 8'hA1, 8'h3C, 8'h00 on consecutive cycles; tx_last only on 8'h00; fifo_count goes 1->0.
2. Back-pressure: same push with tx_ready=0 for 5 cycles, then 1 -> tx_data stays 8'hA1 with tx_valid=1 throughout the stall; the frame then completes unchanged.
3. Back-to-back frames: push 16'h1234 then 16'h5678 on consecutive cycles, tx_ready=1 -> 6 contiguous valid bytes A0 12 34 A0 56 78 with no idle cycle; tx_last on bytes 3 and 6.
4. Overflow: tx_ready=0, push 6 results with DEPTH=4 -> 1 entry in the frame register, 4 buffered, fifo_count=4; the 6th is dropped and ovf=1. Draining yields exactly results 1 to 5 in order.
5. Simultaneous ovf_clr and drop: FIFO full, res_valid=1 and ovf_clr=1 in the same cycle -> ovf remains 1. Next cycle, ovf_clr alone -> ovf=0.
6. Reset mid-frame: assert rst low during the MSB byte -> after that edge tx_valid=0, fifo_count=0, ovf=0. A new push after reset produces a fresh header byte first.
